// File: rtl/inst_fetch.sv
// inst_fetch -- instruction-fetch stage of the five-stage pipeline.
//
// Owns the PC and runs one outstanding request/acknowledge transaction at a
// time on the instruction bus. The fetched word is held for the IF/ID register
// until the pipeline consumes it. Delayed branches from ID are remembered and
// applied at the next consume. Exception flushes redirect the PC right away.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall[5:0]               ctrl stall vector (bit1 = IF stop, bit2 = ID stop)
//   flush, new_pc            exception flush and its redirect address
//   branch_flag_i,
//   branch_target_address_i  taken branch resolved in ID and its target
//   ibus_req_o, ibus_addr_o  instruction bus request and word-aligned address
//   ibus_ack_i, ibus_rdata_i one-cycle acknowledge with its read data
//   if_pc, if_inst           held instruction and its address (0 = bubble)
//   stallreq_from_if         asks ctrl to stall while no instruction is held
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_address_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_ack_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq_from_if
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        HOLD   = 2'd2,
        CANCEL = 2'd3
    } state_t;

    state_t      state_q,      state_d;
    logic [31:0] pc_q,         pc_d;
    logic [31:0] inst_buf_q,   inst_buf_d;
    logic [31:0] if_pc_q,      if_pc_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] redir_tgt_q,  redir_tgt_d;
    logic        req_q,        req_d;
    logic [31:0] addr_q,       addr_d;

    logic        branch_load;
    logic [31:0] branch_tgt;
    logic [31:0] flush_tgt;

    // Only the IF and ID stop bits matter to this stage.
    logic unused_stall_bits;
    assign unused_stall_bits = ^{stall[5:3], stall[0]};

    assign branch_load = branch_flag_i && !stall[2];
    assign branch_tgt  = {branch_target_address_i[31:2], 2'b00};
    assign flush_tgt   = {new_pc[31:2], 2'b00};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_buf_d   = inst_buf_q;
        if_pc_d      = if_pc_q;
        redir_pend_d = redir_pend_q;
        redir_tgt_d  = redir_tgt_q;
        req_d        = req_q;
        addr_d       = addr_q;

        // A branch seen in ID is remembered until the delay slot is consumed.
        if (branch_load) begin
            redir_tgt_d  = branch_tgt;
            redir_pend_d = 1'b1;
        end

        if (flush) begin
            pc_d         = flush_tgt;
            redir_pend_d = 1'b0;
            if_pc_d      = 32'h0;
            inst_buf_d   = 32'h0;
            // A request still waiting for its ack cannot be withdrawn; it is
            // drained in CANCEL with the old address kept on the bus.
            if ((state_q == WAIT || state_q == CANCEL) && !ibus_ack_i) begin
                state_d = CANCEL;
                req_d   = 1'b1;
            end else begin
                state_d = WAIT;
                req_d   = 1'b1;
                addr_d  = flush_tgt;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = WAIT;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
                WAIT: begin
                    if (ibus_ack_i) begin
                        state_d    = HOLD;
                        req_d      = 1'b0;
                        inst_buf_d = ibus_rdata_i;
                        if_pc_d    = pc_q;
                    end
                end
                HOLD: begin
                    if (!stall[1]) begin
                        // Same-edge branch uses the incoming target directly.
                        if (branch_load) begin
                            pc_d = branch_tgt;
                        end else if (redir_pend_q) begin
                            pc_d = redir_tgt_q;
                        end else begin
                            pc_d = pc_q + 32'd4;
                        end
                        redir_pend_d = 1'b0;
                        state_d      = WAIT;
                        req_d        = 1'b1;
                        addr_d       = pc_d;
                        if_pc_d      = 32'h0;
                        inst_buf_d   = 32'h0;
                    end
                end
                CANCEL: begin
                    // Ack of the abandoned fetch: data dropped, refetch new pc.
                    if (ibus_ack_i) begin
                        state_d = WAIT;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= {RESET_PC[31:2], 2'b00};
            redir_pend_q <= 1'b0;
            req_q        <= 1'b0;
            addr_q       <= 32'h0;
            if_pc_q      <= 32'h0;
            inst_buf_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redir_pend_q <= redir_pend_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            if_pc_q      <= if_pc_d;
            inst_buf_q   <= inst_buf_d;
        end
    end

    // Branch target is only meaningful while redir_pend_q is set.
    always_ff @(posedge clk) begin
        redir_tgt_q <= redir_tgt_d;
    end

    assign ibus_req_o       = req_q;
    assign ibus_addr_o      = addr_q;
    assign if_pc            = if_pc_q;
    assign if_inst          = inst_buf_q;
    assign stallreq_from_if = !rst && (state_q != HOLD);

endmodule
